// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - state encoding, opcodes and control codes for multicycle_control
//
// Purpose: shared definitions for the multi-cycle RV32 control FSM.
// Ports:   none (package).

package multicycle_control_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_MATHI  = 7'b0010011;
  localparam logic [6:0] OP_MATHR  = 7'b0110011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // alu_op codes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  // alu_src_a codes
  localparam logic [1:0] SRCA_RS1  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  // wb_sel codes
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // pc_src codes
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_MATHI, OP_MATHR, OP_AUIPC,
      OP_LUI, OP_BRANCH, OP_JAL, OP_JALR: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_wait_timer.sv
// rtl/multicycle_control_wait_timer.sv - bounded memory-wait counter
//
// Purpose: counts cycles a memory request goes unanswered; expired_o flags
//          the last allowed wait cycle (count == LIMIT-1).
// Ports:   clk, rst_n   clock, async active-low reset
//          clear_i      force count to zero (takes priority)
//          en_i         count one more unanswered cycle
//          expired_o    count has reached LIMIT-1

module multicycle_control_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RV32 control FSM with memory handshakes and trap
//
// Purpose: sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and
//          drives the shared datapath's enables, mux selects and alu_op.
// Ports:   clk, rst_n        clock, async active-low reset
//          opcode_i          IR opcode, sampled in DECODE
//          imem_ready_i      instruction word valid
//          dmem_ready_i      data access complete
//          branch_taken_i    ALU compare result, valid in EXEC
//          imem_req_o, ir_write_o          fetch request, IR load
//          dmem_req_o, dmem_we_o           data request, 1 = store
//          alu_op_o, alu_src_a_o, alu_src_b_o  ALU control and operand selects
//          wb_sel_o, reg_write_o           writeback select and enable
//          pc_write_o, pc_src_o            PC update enable and source
//          trap_o                          sticky fault flag

module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT     = 16,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int ALU_OP_W        = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode_i,
  input  logic                imem_ready_i,
  input  logic                dmem_ready_i,
  input  logic                branch_taken_i,
  output logic                imem_req_o,
  output logic                ir_write_o,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic [1:0]          alu_src_a_o,
  output logic                alu_src_b_o,
  output logic [1:0]          wb_sel_o,
  output logic                reg_write_o,
  output logic                pc_write_o,
  output logic [1:0]          pc_src_o,
  output logic                trap_o
);

  state_e     state_q;
  logic [6:0] op_q;

  logic waiting;
  logic ready_sel;
  logic expired;
  logic [1:0] alu_op;

  // FETCH and MEM share one timer; only one of them can be waiting at a time.
  assign waiting   = (state_q == S_FETCH) || (state_q == S_MEM);
  assign ready_sel = (state_q == S_FETCH) ? imem_ready_i : dmem_ready_i;

  multicycle_control_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (!waiting || ready_sel),
    .en_i      (waiting && !ready_sel),
    .expired_o (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_FETCH;
        S_FETCH: begin
          // ready in the expiry cycle wins over the timeout
          if (imem_ready_i)  state_q <= S_DECODE;
          else if (expired)  state_q <= S_TRAP;
        end
        S_DECODE: begin
          op_q <= opcode_i;
          if (is_legal(opcode_i))    state_q <= S_EXEC;
          else if (TRAP_ON_ILLEGAL)  state_q <= S_TRAP;
          else                       state_q <= S_FETCH;
        end
        S_EXEC: begin
          case (op_q)
            OP_LOAD, OP_STORE: state_q <= S_MEM;
            OP_BRANCH:         state_q <= S_FETCH;
            default:           state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem_ready_i)  state_q <= (op_q == OP_STORE) ? S_FETCH : S_WB;
          else if (expired)  state_q <= S_TRAP;
        end
        S_WB:    state_q <= S_FETCH;
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_TRAP;
      endcase
    end
  end

  always_comb begin
    imem_req_o  = 1'b0;
    dmem_req_o  = 1'b0;
    dmem_we_o   = 1'b0;
    alu_op      = ALU_ADD;
    alu_src_a_o = SRCA_RS1;
    alu_src_b_o = 1'b0;
    wb_sel_o    = WB_ALU;
    reg_write_o = 1'b0;
    pc_write_o  = 1'b0;
    pc_src_o    = PC_PLUS4;
    trap_o      = 1'b0;
    case (state_q)
      S_FETCH: imem_req_o = 1'b1;
      S_DECODE: begin
        // illegal opcode retired as NOP: step past it while still in DECODE
        if (!TRAP_ON_ILLEGAL && !is_legal(opcode_i)) begin
          pc_write_o = 1'b1;
          pc_src_o   = PC_PLUS4;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_LOAD, OP_STORE: alu_src_b_o = 1'b1;
          OP_MATHI: begin
            alu_src_b_o = 1'b1;
            alu_op      = ALU_I;
          end
          OP_MATHR: alu_op = ALU_R;
          OP_AUIPC: begin
            alu_src_a_o = SRCA_PC;
            alu_src_b_o = 1'b1;
          end
          OP_LUI: begin
            alu_src_a_o = SRCA_ZERO;
            alu_src_b_o = 1'b1;
          end
          OP_BRANCH: begin
            alu_op     = ALU_BR;
            pc_write_o = 1'b1;
            pc_src_o   = branch_taken_i ? PC_IMM : PC_PLUS4;
          end
          OP_JAL: begin
            pc_write_o = 1'b1;
            pc_src_o   = PC_IMM;
          end
          OP_JALR: begin
            pc_write_o = 1'b1;
            pc_src_o   = PC_JALR;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = (op_q == OP_STORE);
        if (op_q == OP_STORE) begin
          pc_write_o = 1'b1;
          pc_src_o   = PC_PLUS4;
        end
      end
      S_WB: begin
        reg_write_o = 1'b1;
        if (op_q == OP_JAL || op_q == OP_JALR) begin
          // PC was already redirected in EXEC
          wb_sel_o = WB_PC4;
        end else begin
          wb_sel_o   = (op_q == OP_LOAD) ? WB_MEM : WB_ALU;
          pc_write_o = 1'b1;
          pc_src_o   = PC_PLUS4;
        end
      end
      S_TRAP: trap_o = 1'b1;
      default: ;
    endcase
  end

  assign alu_op_o   = ALU_OP_W'(alu_op);
  assign ir_write_o = imem_req_o && imem_ready_i;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control

module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       branch_taken = 1'b0;

  logic       imem_req, ir_write, dmem_req, dmem_we, alu_src_b, reg_write, pc_write, trap;
  logic [1:0] alu_op, alu_src_a, wb_sel, pc_src;

  logic       n_imem_req, n_ir_write, n_dmem_req, n_dmem_we, n_alu_src_b, n_reg_write, n_pc_write, n_trap;
  logic [1:0] n_alu_op, n_alu_src_a, n_wb_sel, n_pc_src;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(16), .TRAP_ON_ILLEGAL(1'b1), .ALU_OP_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .imem_ready_i(imem_ready),
    .dmem_ready_i(dmem_ready), .branch_taken_i(branch_taken),
    .imem_req_o(imem_req), .ir_write_o(ir_write), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
    .alu_op_o(alu_op), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .wb_sel_o(wb_sel),
    .reg_write_o(reg_write), .pc_write_o(pc_write), .pc_src_o(pc_src), .trap_o(trap)
  );

  multicycle_control #(.MEM_TIMEOUT(16), .TRAP_ON_ILLEGAL(1'b0), .ALU_OP_W(2)) dut_nop (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .imem_ready_i(imem_ready),
    .dmem_ready_i(dmem_ready), .branch_taken_i(branch_taken),
    .imem_req_o(n_imem_req), .ir_write_o(n_ir_write), .dmem_req_o(n_dmem_req), .dmem_we_o(n_dmem_we),
    .alu_op_o(n_alu_op), .alu_src_a_o(n_alu_src_a), .alu_src_b_o(n_alu_src_b), .wb_sel_o(n_wb_sel),
    .reg_write_o(n_reg_write), .pc_write_o(n_pc_write), .pc_src_o(n_pc_src), .trap_o(n_trap)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // advance to 2 time units after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // from FETCH: answer the fetch at once, present op in DECODE, land in EXEC
  task automatic fetch_decode(input logic [6:0] op);
    imem_ready = 1'b1;
    #1 check_eq("ir_write_on_ready", {31'd0, ir_write}, 32'd1);
    tick();
    imem_ready = 1'b0;
    opcode = op;
    tick();
  endtask

  // reset, release, then step IDLE -> FETCH
  task automatic reset_to_fetch();
    rst_n = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    branch_taken = 1'b0;
    opcode = 7'd0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int waits;

    // ---- reset state ----
    tick();
    tick();
    #1 check_eq("reset_outputs",
      {16'd0, imem_req, ir_write, dmem_req, dmem_we, alu_op, alu_src_a, alu_src_b, wb_sel,
       reg_write, pc_write, pc_src, trap}, 32'd0);
    rst_n = 1'b1;
    #1 check_eq("idle_no_fetch", {31'd0, imem_req}, 32'd0);
    tick();
    #1 check_eq("fetch_req", {31'd0, imem_req}, 32'd1);

    // ---- R-type, zero wait: FETCH, DECODE, EXEC, WB ----
    fetch_decode(7'b0110011);
    #1 check_eq("rtype_exec_alu", {28'd0, alu_op, 1'b0, alu_src_b}, {28'd0, 2'b10, 1'b0, 1'b0});
    check_eq("rtype_exec_no_rw", {31'd0, reg_write}, 32'd0);
    tick();
    #1 check_eq("rtype_wb", {27'd0, reg_write, pc_write, pc_src, wb_sel[0]}, {27'd0, 1'b1, 1'b1, 2'b00, 1'b0});
    tick();
    #1 check_eq("rtype_back_fetch", {31'd0, imem_req}, 32'd1);

    // ---- load with 3 waits ----
    fetch_decode(7'b0000011);
    #1 check_eq("load_exec", {28'd0, alu_src_a, alu_src_b, 1'b0}, {28'd0, 2'b00, 1'b1, 1'b0});
    tick();
    waits = 0;
    for (int i = 0; i < 3; i++) begin
      #1 if (dmem_req && !dmem_we) waits++;
      tick();
    end
    dmem_ready = 1'b1;
    #1 if (dmem_req && !dmem_we) waits++;
    check_eq("load_dmem_req_cycles", waits, 32'd4);
    tick();
    dmem_ready = 1'b0;
    #1 check_eq("load_wb", {29'd0, wb_sel, reg_write}, {29'd0, 2'b01, 1'b1});
    check_eq("load_wb_no_dreq", {31'd0, dmem_req}, 32'd0);
    tick();

    // ---- branch taken / not taken: 3 cycles ----
    branch_taken = 1'b1;
    fetch_decode(7'b1100011);
    #1 check_eq("br_taken_exec", {26'd0, alu_op, pc_write, pc_src, reg_write}, {26'd0, 2'b01, 1'b1, 2'b01, 1'b0});
    tick();
    #1 check_eq("br_taken_fetch", {31'd0, imem_req}, 32'd1);
    branch_taken = 1'b0;
    fetch_decode(7'b1100011);
    #1 check_eq("br_not_taken_exec", {29'd0, pc_write, pc_src}, {29'd0, 1'b1, 2'b00});
    tick();
    #1 check_eq("br_nt_fetch", {31'd0, imem_req}, 32'd1);

    // ---- JAL: redirect in EXEC, link in WB without a second PC write ----
    fetch_decode(7'b1101111);
    #1 check_eq("jal_exec", {29'd0, pc_write, pc_src}, {29'd0, 1'b1, 2'b01});
    tick();
    #1 check_eq("jal_wb", {28'd0, wb_sel, reg_write, pc_write}, {28'd0, 2'b10, 1'b1, 1'b0});
    tick();

    // ---- JALR / LUI / AUIPC / MATHI operand selects ----
    fetch_decode(7'b1100111);
    #1 check_eq("jalr_exec_pc_src", {30'd0, pc_src}, {30'd0, 2'b10});
    tick(); tick();
    fetch_decode(7'b0110111);
    #1 check_eq("lui_exec", {29'd0, alu_src_a, alu_src_b}, {29'd0, 2'b10, 1'b1});
    tick(); tick();
    fetch_decode(7'b0010111);
    #1 check_eq("auipc_exec", {29'd0, alu_src_a, alu_src_b}, {29'd0, 2'b01, 1'b1});
    tick(); tick();
    fetch_decode(7'b0010011);
    #1 check_eq("mathi_exec", {29'd0, alu_op, alu_src_b}, {29'd0, 2'b11, 1'b1});
    tick(); tick();

    // ---- store, zero wait: 4 cycles ----
    fetch_decode(7'b0100011);
    tick();
    dmem_ready = 1'b1;
    #1 check_eq("store_mem", {28'd0, dmem_req, dmem_we, pc_write, reg_write}, {28'd0, 4'b1110});
    tick();
    dmem_ready = 1'b0;
    #1 check_eq("store_back_fetch", {31'd0, imem_req}, 32'd1);

    // ---- fetch timeout: 16 FETCH cycles then TRAP ----
    reset_to_fetch();
    waits = 0;
    for (int i = 0; i < 16; i++) begin
      #1 if (imem_req && !ir_write && !trap) waits++;
      tick();
    end
    check_eq("timeout_fetch_cycles", waits, 32'd16);
    #1 check_eq("timeout_trap", {30'd0, trap, imem_req}, {30'd0, 1'b1, 1'b0});
    imem_ready = 1'b1;
    #1 check_eq("trap_ignores_ready", {31'd0, ir_write}, 32'd0);
    tick();
    imem_ready = 1'b0;
    #1 check_eq("trap_sticky", {31'd0, trap}, 32'd1);

    // ---- ready on the 16th FETCH cycle wins ----
    reset_to_fetch();
    repeat (15) tick();
    imem_ready = 1'b1;
    #1 check_eq("late_ready_no_trap", {30'd0, trap, ir_write}, {30'd0, 1'b0, 1'b1});
    tick();
    imem_ready = 1'b0;
    #1 check_eq("late_ready_decode", {30'd0, trap, imem_req}, 32'd0);

    // ---- illegal opcode: trapping vs NOP-retire instance ----
    opcode = 7'b1111111;
    #1 check_eq("illegal_nop_decode", {29'd0, n_pc_write, n_pc_src}, {29'd0, 1'b1, 2'b00});
    tick();
    #1 check_eq("illegal_trap", {31'd0, trap}, 32'd1);
    check_eq("illegal_nop_fetch", {30'd0, n_imem_req, n_trap}, {30'd0, 1'b1, 1'b0});

    // ---- reset during store MEM ----
    reset_to_fetch();
    fetch_decode(7'b0100011);
    tick();
    #1 check_eq("store_mem_req", {30'd0, dmem_req, dmem_we}, {30'd0, 2'b11});
    rst_n = 1'b0;
    #1 check_eq("async_reset_drop", {30'd0, dmem_req, trap}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1 check_eq("after_reset_idle", {30'd0, imem_req, trap}, 32'd0);
    tick();
    #1 check_eq("after_reset_fetch", {30'd0, imem_req, trap}, {30'd0, 1'b1, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
